// File: rtl/zeroriscy_hpm_counters.sv
// Hardware performance-monitor counters for zero-riscy: N_CNT event counters with per-counter
// event selectors, wrap/saturate, sticky overflow and a maskable interrupt on the CSR bus.
module zeroriscy_hpm_cnt #(
  parameter int N_EVENTS  = 16,
  parameter int CNT_WIDTH = 40,
  parameter int EVT_W     = 4,
  parameter int RST_SEL   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic                 sat_i,
  input  logic [N_EVENTS-1:0]  evt_i,
  input  logic                 wr_sel_i,
  input  logic                 wr_lo_i,
  input  logic                 wr_hi_i,
  input  logic [31:0]          wdata_i,
  output logic [EVT_W-1:0]     sel_o,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 ovf_set_o
);
  logic [EVT_W-1:0]     sel_q, sel_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 inc;

  assign inc = en_i & (int'(sel_q) < N_EVENTS) & evt_i[sel_q];

  // CSR writes to either half take the whole cycle; the increment is discarded.
  always_comb begin
    cnt_d     = cnt_q;
    ovf_set_o = 1'b0;
    if (wr_lo_i) begin
      cnt_d[31:0] = wdata_i;
    end else if (wr_hi_i) begin
      cnt_d[CNT_WIDTH-1:32] = wdata_i[CNT_WIDTH-33:0];
    end else if (inc) begin
      if (&cnt_q) begin
        ovf_set_o = 1'b1;
        cnt_d     = sat_i ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign sel_d = wr_sel_i ? wdata_i[EVT_W-1:0] : sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= EVT_W'(RST_SEL);
      cnt_q <= '0;
    end else begin
      sel_q <= sel_d;
      cnt_q <= cnt_d;
    end
  end

  assign sel_o = sel_q;
  assign cnt_o = cnt_q;
endmodule

module zeroriscy_hpm_counters #(
  parameter int N_EVENTS  = 16,
  parameter int N_CNT     = 4,
  parameter int CNT_WIDTH = 40
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                csr_access_i,
  input  logic [11:0]         csr_addr_i,
  input  logic [31:0]         csr_wdata_i,
  input  logic [1:0]          csr_op_i,
  output logic [31:0]         csr_rdata_o,
  output logic                csr_hit_o,
  input  logic [N_EVENTS-1:0] event_i,
  output logic                ovf_irq_o
);
  localparam int EVT_W = $clog2(N_EVENTS);
  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic [2:0]                          ctrl_q, ctrl_d;
  logic [N_CNT-1:0]                    ovf_q, ovf_d, irqen_q, irqen_d, ovf_set;
  logic [N_EVENTS-1:0]                 evt_q;
  logic [N_CNT-1:0][CNT_WIDTH-1:0]     cnt;
  logic [N_CNT-1:0][EVT_W-1:0]         sel;
  logic [3:0]                          idx;
  logic                                idx_ok, hit_ctrl, hit_ovf, hit_irqen, hit_sel, hit_lo, hit_hi;
  logic                                we, cnt_en;
  logic [31:0]                         rdata, wval;

  assign idx       = csr_addr_i[3:0];
  assign idx_ok    = int'(idx) < N_CNT;
  assign hit_ctrl  = csr_addr_i == 12'h7C0;
  assign hit_ovf   = csr_addr_i == 12'h7C1;
  assign hit_irqen = csr_addr_i == 12'h7C2;
  assign hit_sel   = (csr_addr_i[11:4] == 8'h7D) & idx_ok;
  assign hit_lo    = (csr_addr_i[11:4] == 8'hB0) & idx_ok;
  assign hit_hi    = (csr_addr_i[11:4] == 8'hB8) & idx_ok;
  assign csr_hit_o = csr_access_i & (hit_ctrl | hit_ovf | hit_irqen | hit_sel | hit_lo | hit_hi);

  always_comb begin
    rdata = '0;
    if (hit_ctrl)  rdata = {29'b0, ctrl_q};
    if (hit_ovf)   rdata = 32'(ovf_q);
    if (hit_irqen) rdata = 32'(irqen_q);
    for (int k = 0; k < N_CNT; k++) begin
      if (int'(idx) == k) begin
        if (hit_sel) rdata = 32'(sel[k]);
        if (hit_lo)  rdata = cnt[k][31:0];
        if (hit_hi)  rdata = 32'(cnt[k][CNT_WIDTH-1:32]);
      end
    end
  end

  assign csr_rdata_o = csr_hit_o ? rdata : 32'b0;

  always_comb begin
    unique case (csr_op_i)
      OP_WRITE: wval = csr_wdata_i;
      OP_SET:   wval = rdata | csr_wdata_i;
      OP_CLEAR: wval = rdata & ~csr_wdata_i;
      default:  wval = rdata;
    endcase
  end

  assign we = csr_hit_o & (csr_op_i != OP_NONE);

  assign ctrl_d  = (we & hit_ctrl)  ? wval[2:0]       : ctrl_q;
  assign irqen_d = (we & hit_irqen) ? wval[N_CNT-1:0] : irqen_q;
  // Hardware overflow wins over a same-cycle software clear.
  assign ovf_d   = ((we & hit_ovf)  ? wval[N_CNT-1:0] : ovf_q) | ovf_set;

  assign cnt_en  = ctrl_q[0] & ~(ctrl_q[2] & |ovf_q);

  for (genvar k = 0; k < N_CNT; k++) begin : g_cnt
    zeroriscy_hpm_cnt #(
      .N_EVENTS (N_EVENTS),
      .CNT_WIDTH(CNT_WIDTH),
      .EVT_W    (EVT_W),
      .RST_SEL  (k % N_EVENTS)
    ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (cnt_en),
      .sat_i    (ctrl_q[1]),
      .evt_i    (evt_q),
      .wr_sel_i (we & hit_sel & (int'(idx) == k)),
      .wr_lo_i  (we & hit_lo  & (int'(idx) == k)),
      .wr_hi_i  (we & hit_hi  & (int'(idx) == k)),
      .wdata_i  (wval),
      .sel_o    (sel[k]),
      .cnt_o    (cnt[k]),
      .ovf_set_o(ovf_set[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= 3'b001;
      ovf_q   <= '0;
      irqen_q <= '0;
      evt_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      ovf_q   <= ovf_d;
      irqen_q <= irqen_d;
      evt_q   <= event_i;
    end
  end

  assign ovf_irq_o = |(ovf_q & irqen_q);
endmodule
